ram_copy_engine: RTL and testbench

//  Sequencer that drives both ports of one dualportram instance to run block fill and memmove-correct block copy.

---
 rtl/ram_copy_engine_if.sv | 40 ++++
 rtl/ram_copy_engine.sv | 177 +++++++++++++++++
 tb/tb_ram_copy_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_copy_engine_if.sv
// Bundles the command handshake and both RAM ports of ram_copy_engine.
// master: the copy engine. slave: the controller plus the attached RAM.
interface ram_copy_engine_if #(
  parameter int WIDTH = 32
);
  // Command side
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [31:0]      count;
  logic [WIDTH-1:0] fill_value;
  logic             busy;
  logic             done;
  logic             error;
  // RAM port A (read only)
  logic             ram_we;
  logic             ram_oe;
  logic [31:0]      ram_address;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;
  // RAM port B (write only)
  logic             ram_we_b;
  logic             ram_oe_b;
  logic [31:0]      ram_address_b;
  logic [WIDTH-1:0] ram_din_b;
  logic [31:0]      ram_length;

  modport master (
    input  start, mode, src_addr, dst_addr, count, fill_value, ram_dout, ram_length,
    output busy, done, error, ram_we, ram_oe, ram_address, ram_din,
           ram_we_b, ram_oe_b, ram_address_b, ram_din_b
  );

  modport slave (
    output start, mode, src_addr, dst_addr, count, fill_value, ram_dout, ram_length,
    input  busy, done, error, ram_we, ram_oe, ram_address, ram_din,
           ram_we_b, ram_oe_b, ram_address_b, ram_din_b
  );
endinterface

// File: rtl/ram_copy_engine.sv
// Block fill / memmove-correct block copy sequencer for one dual-port RAM.
// Port A only reads, port B only writes; one word per clock in both modes.
// Copy runs descending when the destination overlaps above the source so
// that every source word is read before it is overwritten.
module ram_copy_engine #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  ram_copy_engine_if.master bus
);

  typedef enum logic [2:0] {IDLE, COPY, DRAIN, FILL, FIN} state_t;

  // Never let ram_length claim more words than the attached RAM decodes.
  localparam logic [32:0] WORDS = 33'd1 << DEPTH;

  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic             oe_q, oe_d, we_b_q, we_b_d;
  logic [31:0]      addr_q, addr_d, addr_b_q, addr_b_d;
  logic [31:0]      src_ptr_q, src_ptr_d, dst_ptr_q, dst_ptr_d;
  logic [31:0]      left_q, left_d;
  logic             down_q, down_d;
  logic [WIDTH-1:0] fill_q, fill_d;

  logic [32:0] limit, src_end, dst_end;
  logic        bad_range, overlap_down;
  logic [31:0] cnt_m1;

  function automatic logic [31:0] step(input logic [31:0] p, input logic down);
    return down ? p - 32'd1 : p + 32'd1;
  endfunction

  // Command decode on the raw inputs; only consulted on the accepting edge.
  always_comb begin
    limit        = ({1'b0, bus.ram_length} > WORDS) ? WORDS : {1'b0, bus.ram_length};
    src_end      = {1'b0, bus.src_addr} + {1'b0, bus.count};
    dst_end      = {1'b0, bus.dst_addr} + {1'b0, bus.count};
    bad_range    = (dst_end > limit) || (!bus.mode && (src_end > limit));
    overlap_down = (bus.dst_addr > bus.src_addr) && ({1'b0, bus.dst_addr} < src_end);
    cnt_m1       = bus.count - 32'd1;
  end

  // Next state and next value of every registered output.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    oe_d      = 1'b0;
    we_b_d    = 1'b0;
    addr_d    = addr_q;
    addr_b_d  = addr_b_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    left_d    = left_q;
    down_d    = down_q;
    fill_d    = fill_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bad_range) begin
            error_d = 1'b1;
          end else if (bus.count == 32'd0) begin
            done_d = 1'b1;
          end else if (bus.mode) begin
            // Fill: first write goes out on the very next clock.
            we_b_d    = 1'b1;
            addr_b_d  = bus.dst_addr;
            dst_ptr_d = bus.dst_addr + 32'd1;
            left_d    = cnt_m1;
            fill_d    = bus.fill_value;
            down_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = FILL;
          end else begin
            // Copy: first read goes out now, its write follows one clock later.
            down_d    = overlap_down;
            addr_d    = overlap_down ? bus.src_addr + cnt_m1 : bus.src_addr;
            src_ptr_d = step(addr_d, overlap_down);
            dst_ptr_d = overlap_down ? bus.dst_addr + cnt_m1 : bus.dst_addr;
            oe_d      = 1'b1;
            left_d    = cnt_m1;
            busy_d    = 1'b1;
            state_d   = COPY;
          end
        end
      end
      COPY: begin
        busy_d    = 1'b1;
        we_b_d    = 1'b1;
        addr_b_d  = dst_ptr_q;
        dst_ptr_d = step(dst_ptr_q, down_q);
        if (left_q != 32'd0) begin
          oe_d      = 1'b1;
          addr_d    = src_ptr_q;
          src_ptr_d = step(src_ptr_q, down_q);
          left_d    = left_q - 32'd1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = FIN;
      end
      FILL: begin
        if (left_q != 32'd0) begin
          busy_d    = 1'b1;
          we_b_d    = 1'b1;
          addr_b_d  = dst_ptr_q;
          dst_ptr_d = dst_ptr_q + 32'd1;
          left_d    = left_q - 32'd1;
        end else begin
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any transfer and every strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      oe_q      <= 1'b0;
      we_b_q    <= 1'b0;
      addr_q    <= '0;
      addr_b_q  <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      left_q    <= '0;
      down_q    <= 1'b0;
      fill_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      oe_q      <= oe_d;
      we_b_q    <= we_b_d;
      addr_q    <= addr_d;
      addr_b_q  <= addr_b_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      left_q    <= left_d;
      down_q    <= down_d;
      fill_q    <= fill_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.error         = error_q;
  assign bus.ram_we        = 1'b0;
  assign bus.ram_oe        = oe_q;
  assign bus.ram_address   = addr_q;
  assign bus.ram_din       = '0;
  assign bus.ram_we_b      = we_b_q;
  assign bus.ram_oe_b      = 1'b0;
  assign bus.ram_address_b = addr_b_q;
  // Copy data passes straight from port A to port B to hold 1 word/clk.
  assign bus.ram_din_b     = (state_q == COPY || state_q == DRAIN) ? bus.ram_dout : fill_q;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Bench for ram_copy_engine: bench-side RAM, a memmove/fill reference model
// with a per-cycle output compare, and literal expectations per scenario.
module tb_ram_copy_engine;
  localparam int WIDTH = 32;
  localparam int WORDS = 1024;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ram_copy_engine_if #(.WIDTH(WIDTH)) bus ();
  ram_copy_engine #(.DEPTH(10), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench RAM: port A read with 1-clk latency, port B write, read-before-write.
  logic [WIDTH-1:0] mem [WORDS];
  logic             pre_we;
  logic [9:0]       pre_addr;
  logic [WIDTH-1:0] pre_data;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else begin
      if (bus.ram_oe)   bus.ram_dout <= mem[bus.ram_address[9:0]];
      if (bus.ram_we_b) mem[bus.ram_address_b[9:0]] <= bus.ram_din_b;
    end
  end

  // Reference model
  logic [WIDTH-1:0] ref_mem [WORDS];
  logic [WIDTH-1:0] snap    [WORDS];
  logic [31:0]      exp_rd_addr [WORDS];
  logic [31:0]      exp_wr_addr [WORDS];
  logic [WIDTH-1:0] exp_wr_data [WORDS];
  bit cmd_active = 1'b0;
  int base = 0, busy_last, done_k, err_k, rd_first, rd_last, wr_first, wr_last;
  // Observed per command
  int n_wr, first_wr_k, last_wr_k, obs_done_k, obs_err_k;
  bit busy_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_setup(input bit m, input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] cnt, input logic [WIDTH-1:0] fv);
    logic [32:0] s_end, d_end;
    bit bad, down;
    int n, idx;
    s_end = {1'b0, src} + {1'b0, cnt};
    d_end = {1'b0, dst} + {1'b0, cnt};
    bad   = (d_end > 33'(WORDS)) || (!m && s_end > 33'(WORDS));
    n     = int'(cnt);
    busy_last = 0; done_k = -1; err_k = -1;
    rd_first = 1; rd_last = 0; wr_first = 1; wr_last = 0;
    if (bad) err_k = 1;
    else if (n == 0) done_k = 1;
    else if (m) begin
      busy_last = n; wr_first = 1; wr_last = n; done_k = n + 1;
      for (int i = 0; i < n; i++) begin
        exp_wr_addr[i] = dst + 32'(i);
        exp_wr_data[i] = fv;
        ref_mem[int'(dst) + i] = fv;
      end
    end else begin
      busy_last = n + 1; rd_first = 1; rd_last = n; wr_first = 2; wr_last = n + 1;
      done_k = n + 2;
      down = (dst > src) && ({1'b0, dst} < s_end);
      for (int i = 0; i < n; i++) snap[i] = ref_mem[int'(src) + i];
      for (int j = 0; j < n; j++) begin
        idx = down ? n - 1 - j : j;
        exp_rd_addr[j] = src + 32'(idx);
        exp_wr_addr[j] = dst + 32'(idx);
        exp_wr_data[j] = snap[idx];
      end
      for (int i = 0; i < n; i++) ref_mem[int'(dst) + i] = snap[i];
    end
  endtask

  // Per-cycle compare against the model (negedge, away from the active edge).
  always @(negedge clk) begin
    int k;
    bit e_busy, e_done, e_err, e_oe, e_we;
    if (!reset) begin
      k      = cyc - base;
      e_busy = cmd_active && k >= 1 && k <= busy_last;
      e_done = cmd_active && k == done_k;
      e_err  = cmd_active && k == err_k;
      e_oe   = cmd_active && k >= rd_first && k <= rd_last;
      e_we   = cmd_active && k >= wr_first && k <= wr_last;
      check("busy",     32'(bus.busy),     32'(e_busy));
      check("done",     32'(bus.done),     32'(e_done));
      check("error",    32'(bus.error),    32'(e_err));
      check("ram_oe",   32'(bus.ram_oe),   32'(e_oe));
      check("ram_we_b", 32'(bus.ram_we_b), 32'(e_we));
      check("ram_we",   32'(bus.ram_we),   32'd0);
      check("ram_oe_b", 32'(bus.ram_oe_b), 32'd0);
      check("ram_din",  bus.ram_din,       32'd0);
      if (e_oe) check("ram_address", bus.ram_address, exp_rd_addr[k - rd_first]);
      if (e_we) begin
        check("ram_address_b", bus.ram_address_b, exp_wr_addr[k - wr_first]);
        check("ram_din_b",     bus.ram_din_b,     exp_wr_data[k - wr_first]);
      end
      if (bus.ram_we_b) begin
        n_wr++;
        if (first_wr_k < 0) first_wr_k = k;
        last_wr_k = k;
      end
      if (bus.done)  obs_done_k = k;
      if (bus.error) obs_err_k  = k;
      if (bus.busy)  busy_seen  = 1'b1;
    end
  end

  task automatic drive_cmd(input bit m, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] cnt, input logic [WIDTH-1:0] fv);
    bus.start = 1'b1; bus.mode = m; bus.src_addr = src; bus.dst_addr = dst;
    bus.count = cnt; bus.fill_value = fv;
    base = cyc;
    model_setup(m, src, dst, cnt, fv);
    n_wr = 0; first_wr_k = -1; last_wr_k = -1; obs_done_k = -1; obs_err_k = -1;
    busy_seen = 1'b0;
    cmd_active = 1'b1;
    @(negedge clk); #1;
    // Inputs are free to change once the command is taken.
    bus.start = 1'b0; bus.mode = ~m; bus.src_addr = 32'hDEAD_BEEF;
    bus.dst_addr = 32'hFFFF_FFF0; bus.count = 32'hFFFF_FFFF; bus.fill_value = 32'h1234_5678;
  endtask

  task automatic issue(input bit m, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] cnt, input logic [WIDTH-1:0] fv);
    @(negedge clk); #1;
    drive_cmd(m, src, dst, cnt, fv);
  endtask

  task automatic wait_done();
    int lim;
    lim = busy_last;
    if (done_k > lim) lim = done_k;
    if (err_k > lim)  lim = err_k;
    while (cyc - base <= lim + 1) @(negedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [WIDTH-1:0] d);
    @(negedge clk); #1;
    pre_we = 1'b1; pre_addr = 10'(a); pre_data = d;
    ref_mem[a] = d;
  endtask

  task automatic poke_end();
    @(negedge clk); #1;
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_addr = '0; bus.dst_addr = '0;
    bus.count = '0; bus.fill_value = '0; bus.ram_length = 32'(WORDS);
    bus.ram_dout = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(bus.busy),     32'd0);
    check("rst_done",   32'(bus.done),     32'd0);
    check("rst_error",  32'(bus.error),    32'd0);
    check("rst_we_b",   32'(bus.ram_we_b), 32'd0);
    check("rst_oe",     32'(bus.ram_oe),   32'd0);
    check("rst_addr",   bus.ram_address,   32'd0);
    check("rst_addr_b", bus.ram_address_b, 32'd0);
    check("rst_din_b",  bus.ram_din_b,     32'd0);

    for (int i = 0; i < WORDS; i++) poke(i, 32'(i));
    poke_end();
    @(negedge clk); #1 reset = 1'b0;

    // Fill dst=10 count=4
    issue(1'b1, 32'd0, 32'd10, 32'd4, 32'hA5);
    wait_done();
    for (int i = 10; i < 14; i++) check("fill_word", mem[i], 32'hA5);
    check("fill_below", mem[9],  32'd9);
    check("fill_above", mem[14], 32'd14);
    check("fill_done_T", 32'(obs_done_k), 32'd5);
    check("fill_nwr",    32'(n_wr),       32'd4);

    // Copy src=0 dst=100 count=8
    issue(1'b0, 32'd0, 32'd100, 32'd8, 32'h0);
    wait_done();
    for (int i = 0; i < 8; i++) check("copy_word", mem[100 + i], 32'(i));
    check("copy_done_T",   32'(obs_done_k), 32'd10);
    check("copy_nwr",      32'(n_wr),       32'd8);
    check("copy_first_wr", 32'(first_wr_k), 32'd2);
    check("copy_last_wr",  32'(last_wr_k),  32'd9);

    // Overlap, destination above source: descending
    issue(1'b0, 32'd0, 32'd2, 32'd4, 32'h0);
    wait_done();
    for (int i = 0; i < 4; i++) check("ovl_down_word", mem[2 + i], 32'(i));

    // Overlap, destination below source: ascending
    for (int i = 0; i < 6; i++) poke(i, 32'(i));
    poke_end();
    issue(1'b0, 32'd2, 32'd0, 32'd4, 32'h0);
    wait_done();
    for (int i = 0; i < 4; i++) check("ovl_up_word", mem[i], 32'(i + 2));

    // src == dst
    issue(1'b0, 32'd20, 32'd20, 32'd3, 32'h0);
    wait_done();
    for (int i = 20; i < 23; i++) check("same_word", mem[i], 32'(i));

    // Range boundaries
    issue(1'b1, 32'd0, 32'd1020, 32'd5, 32'h99);
    wait_done();
    check("err_fill_T",    32'(obs_err_k), 32'd1);
    check("err_fill_nwr",  32'(n_wr),      32'd0);
    check("err_fill_busy", 32'(busy_seen), 32'd0);
    issue(1'b0, 32'd1020, 32'd0, 32'd5, 32'h0);
    wait_done();
    check("err_copy_T",   32'(obs_err_k), 32'd1);
    check("err_copy_nwr", 32'(n_wr),      32'd0);
    issue(1'b1, 32'd0, 32'd1019, 32'd5, 32'h77);
    wait_done();
    check("fit_last_word", mem[1023], 32'h77);
    check("fit_done_T",    32'(obs_done_k), 32'd6);

    // count == 0
    issue(1'b0, 32'd5, 32'd6, 32'd0, 32'h0);
    wait_done();
    check("zero_done_T", 32'(obs_done_k), 32'd1);
    check("zero_busy",   32'(busy_seen),  32'd0);

    // start pulsed mid-copy is ignored
    issue(1'b0, 32'd200, 32'd300, 32'd10, 32'h0);
    repeat (3) @(negedge clk);
    #1 bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 32'd0; bus.count = 32'd5;
    @(negedge clk); #1 bus.start = 1'b0;
    wait_done();
    check("mid_done_T", 32'(obs_done_k), 32'd12);
    check("mid_nwr",    32'(n_wr),       32'd10);
    check("mid_no_err", 32'(obs_err_k + 1), 32'd0);

    // start during FIN is ignored, accepted on the following clock
    issue(1'b0, 32'd600, 32'd610, 32'd3, 32'h0);
    while (cyc - base < 5) @(negedge clk);
    #1 bus.start = 1'b1; bus.mode = 1'b1; bus.dst_addr = 32'd700; bus.count = 32'd2;
    bus.fill_value = 32'hFF;
    @(negedge clk); #1;
    drive_cmd(1'b1, 32'd0, 32'd700, 32'd2, 32'hFF);
    wait_done();
    check("fin_fill_done_T", 32'(obs_done_k), 32'd3);
    check("fin_fill_w0",     mem[700], 32'hFF);
    check("fin_fill_w1",     mem[701], 32'hFF);

    // Reset mid-copy, then a later command works
    issue(1'b0, 32'd400, 32'd500, 32'd20, 32'h0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("pre_reset_we_b", 32'(bus.ram_we_b), 32'd1);
    #1 reset = 1'b1; cmd_active = 1'b0;
    #1;
    check("abort_we_b", 32'(bus.ram_we_b), 32'd0);
    check("abort_busy", 32'(bus.busy),     32'd0);
    check("abort_oe",   32'(bus.ram_oe),   32'd0);
    @(negedge clk); #1 reset = 1'b0;
    issue(1'b1, 32'd0, 32'd500, 32'd20, 32'h5A);
    wait_done();
    check("after_rst_done_T", 32'(obs_done_k), 32'd21);
    check("after_rst_word",   mem[519], 32'h5A);

    // Whole memory against the model
    for (int i = 0; i < WORDS; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
